mul_32bits_seq: RTL



---
 rtl/mul_32bits_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mul_32bits_seq.sv
// Iterative 32x32->64 shift-and-add multiplier driven through one reused carry-select adder.
// Latency: 32 cycles from the accepting start edge to the done pulse; one result per 33 cycles back-to-back.
// Backpressure: none; start is sampled only in IDLE or DONE and is ignored while busy (no queuing).
//
// Ports: clk, rst_n (async active-low), start, a, b (operands captured on accepted start),
//        sgn (only with MUL_SIGNED_EN: signed-mode request), busy (high in CALC),
//        done (one-cycle pulse), product (64-bit result register, held until next done).
// Optional feature macro: MUL_SIGNED_EN adds the sgn port and two's-complement signed mode.

// 32-bit carry-select adder: 4-bit blocks each precompute both carry-in cases,
// and the real block carry picks one.
module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [8:0] c;
    assign c[0] = ci;

    for (genvar g = 0; g < 8; g++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;
        assign r0 = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]};
        assign r1 = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]} + 5'd1;
        assign s[g*4 +: 4] = c[g] ? r1[3:0] : r0[3:0];
        assign c[g+1]      = c[g] ? r1[4]   : r0[4];
    end

    assign co = c[8];
endmodule

module mul_32bits_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MUL_SIGNED_EN
    input  logic        sgn,
`endif
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] mcand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [4:0]  cnt;
    logic        load;
    logic        last;

    logic [31:0] add_b;
    logic [31:0] sum;
    logic        carry;
    logic [63:0] acc_nxt;
    logic [63:0] result;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Only one adder exists; it adds the multiplicand into the high half
    // whenever the multiplier bit currently at acc_lo[0] is set.
    assign add_b = acc_lo[0] ? mcand : 32'd0;

    adder_32bits u_add (
        .a  (acc_hi),
        .b  (add_b),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    // 65-bit {co, s, acc_lo} shifted right by one; the carry lands in bit 63
    // so no product bit is ever lost.
    assign acc_nxt = {carry, sum, acc_lo[31:1]};

`ifdef MUL_SIGNED_EN
    logic neg;
    // Two's-complement magnitude; 0x80000000 maps onto itself, read as 2^31 unsigned.
    assign a_mag  = (sgn && a[31]) ? (~a + 32'd1) : a;
    assign b_mag  = (sgn && b[31]) ? (~b + 32'd1) : b;
    assign result = neg ? (~acc_nxt + 64'd1) : acc_nxt;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc_nxt;
`endif

    assign load = start && (state == IDLE || state == DONE);
    assign last = (state == CALC) && (cnt == 5'd31);
    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= 32'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            cnt     <= 5'd0;
            product <= 64'd0;
`ifdef MUL_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else if (load) begin
            mcand  <= a_mag;
            acc_hi <= 32'd0;
            acc_lo <= b_mag;
            cnt    <= 5'd0;
`ifdef MUL_SIGNED_EN
            neg    <= sgn && (a[31] ^ b[31]);
`endif
        end else if (state == CALC) begin
            {acc_hi, acc_lo} <= acc_nxt;
            cnt              <= cnt + 5'd1;
            // Result register is loaded on the same edge that enters DONE.
            if (last) begin
                product <= result;
            end
        end
    end
endmodule
